// File: rtl/fuserisc_wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fuserisc_wb_pkg                                                |
// | Purpose : Shared Wishbone definitions for the FuseRISC core-side bus     |
// |           bridges: bus widths, default hung-bus timeout, FSM states.     |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package fuserisc_wb_pkg;

  localparam int WB_SEL_W        = 4;
  localparam int WB_DAT_W        = 32;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/core_to_wb_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : core_to_wb_master_if                                         |
// | Purpose   : Groups the core data port (req/gnt/rvalid) and the classic   |
// |             Wishbone B4 master signals of the core-to-Wishbone bridge.   |
// | Modports  : master - the bridge side (drives gnt/rvalid/rdata/err and    |
// |                      all wbm_* outputs, samples core requests + slave)   |
// |             slave  - the surrounding core + Wishbone slave side          |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface core_to_wb_master_if
  import fuserisc_wb_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  // Core data port
  logic                core_data_req_i;
  logic                core_data_gnt_o;
  logic [ADDR_W-1:0]   core_data_addr_i;
  logic                core_data_we_i;
  logic [WB_SEL_W-1:0] core_data_be_i;
  logic [WB_DAT_W-1:0] core_data_wdata_i;
  logic                core_data_rvalid_o;
  logic [WB_DAT_W-1:0] core_data_rdata_o;
  logic                core_data_err_o;

  // Wishbone master port
  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [WB_SEL_W-1:0] wbm_sel_o;
  logic [ADDR_W-1:0]   wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_o;
  logic [WB_DAT_W-1:0] wbm_dat_i;
  logic                wbm_ack_i;
  logic                wbm_err_i;

  modport master (
    input  core_data_req_i, core_data_addr_i, core_data_we_i,
           core_data_be_i, core_data_wdata_i,
    output core_data_gnt_o, core_data_rvalid_o, core_data_rdata_o,
           core_data_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output core_data_req_i, core_data_addr_i, core_data_we_i,
           core_data_be_i, core_data_wdata_i,
    input  core_data_gnt_o, core_data_rvalid_o, core_data_rdata_o,
           core_data_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );

endinterface
`default_nettype wire

// File: rtl/core_to_wb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : core_to_wb_master                                              |
// | Purpose : Bridges the core data port (req/gnt/rvalid) onto a classic     |
// |           Wishbone B4 master. One outstanding single-beat transfer with  |
// |           byte enables; an unanswered strobe is terminated with an       |
// |           error after TIMEOUT cycles so a hung slave cannot stall core.  |
// | Ports   : wb_clk_i  - clock for all logic                                |
// |           wb_rst_i  - reset, asynchronous assert, active-high            |
// |           bus       - core_to_wb_master_if.master (core + Wishbone)      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module core_to_wb_master
  import fuserisc_wb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 8
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  core_to_wb_master_if.master bus
);

  localparam logic [1:0]      c_IDLE    = IDLE;
  localparam logic [1:0]      c_BUS     = BUS;
  localparam logic [1:0]      c_RESP    = RESP;
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] c_TO_MAX  = {TO_W{1'b1}};

  logic [1:0]          r_rst_sync;
  logic                w_rst;
  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_adr;
  logic                r_we;
  logic [WB_SEL_W-1:0] r_sel;
  logic [WB_DAT_W-1:0] r_wdat;
  logic [WB_DAT_W-1:0] r_rdata;
  logic                r_err;
  logic [TO_W-1:0]     r_to_cnt;
  logic                w_cyc;
  logic                w_rvalid;
  logic                w_timeout;

  // Reset asserts immediately; release is re-timed to wb_clk_i so the FSM
  // never leaves reset on an arbitrary edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign w_rst     = r_rst_sync[1];
  assign w_cyc     = (r_state == c_BUS);
  assign w_rvalid  = (r_state == c_RESP);
  // Counter holds the number of strobe cycles already completed, so this
  // fires on the TIMEOUT-th strobe cycle.
  assign w_timeout = (r_to_cnt == c_TO_LAST);

  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst) begin
      r_state  <= c_IDLE;
      r_adr    <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_wdat   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.core_data_req_i) begin
            r_adr    <= bus.core_data_addr_i;
            r_we     <= bus.core_data_we_i;
            r_sel    <= bus.core_data_be_i;
            r_wdat   <= bus.core_data_wdata_i;
            r_to_cnt <= '0;
            r_state  <= c_BUS;
          end
        end
        c_BUS: begin
          if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
          // Priority: slave error, then ack, then our own timeout.
          if (bus.wbm_err_i) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= c_RESP;
          end else if (bus.wbm_ack_i) begin
            r_rdata <= r_we ? '0 : bus.wbm_dat_i;
            r_err   <= 1'b0;
            r_state <= c_RESP;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= c_RESP;
          end
        end
        c_RESP: begin
          r_to_cnt <= '0;
          r_state  <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Grant is only possible while idle and out of reset.
  assign bus.core_data_gnt_o    = (r_state == c_IDLE) & bus.core_data_req_i & ~w_rst;
  assign bus.core_data_rvalid_o = w_rvalid;
  assign bus.core_data_rdata_o  = w_rvalid ? r_rdata : '0;
  assign bus.core_data_err_o    = w_rvalid & r_err;

  // Wishbone outputs are forced to zero outside a cycle.
  assign bus.wbm_cyc_o = w_cyc;
  assign bus.wbm_stb_o = w_cyc;
  assign bus.wbm_we_o  = w_cyc & r_we;
  assign bus.wbm_sel_o = w_cyc ? r_sel  : '0;
  assign bus.wbm_adr_o = w_cyc ? r_adr  : '0;
  assign bus.wbm_dat_o = w_cyc ? r_wdat : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_to_wb_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_core_to_wb_master                                           |
// | Purpose : Self-checking bench for core_to_wb_master. A driver issues     |
// |           directed then random core requests; a Wishbone slave model     |
// |           answers per a per-transfer plan; a monitor compares each       |
// |           rvalid response against a queue of expected results.          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_core_to_wb_master;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;

  typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int unsigned dly;   // strobe cycle on which the slave answers
    kind_e       kind;
    logic [31:0] sdat;  // slave read data on ack
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_to_wb_master_if #(.ADDR_W(ADDR_W)) bus ();

  core_to_wb_master #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus.master)
  );

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          directed = 1'b0;  // slave model stands aside
  bit          stray    = 1'b0;  // slave model floods ack/err

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
  endfunction

  function automatic void fail(string name);
    n_total++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // Reference: a response carries data only for a clean ack on a read;
  // any slave error or the absence of an answer yields err=1, rdata=0.
  function automatic exp_t model(plan_t p);
    exp_t e;
    e.err   = (p.kind != K_ACK);
    e.rdata = (p.kind == K_ACK && !p.we) ? p.sdat : 32'h0;
    return e;
  endfunction

  function automatic int unsigned stb_len(plan_t p);
    return (p.kind == K_NONE) ? TIMEOUT : p.dly;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    p.we   = 1'($urandom_range(0, 1));
    p.adr  = $urandom;
    p.sel  = 4'($urandom_range(0, 15));
    p.wdat = $urandom;
    p.kind = kind_e'($urandom_range(0, 3));
    p.dly  = $urandom_range(1, TIMEOUT);
    p.sdat = $urandom;
    return p;
  endfunction

  function automatic plan_t mk(logic we, logic [31:0] adr, logic [3:0] sel,
                               logic [31:0] wdat, kind_e kind, int unsigned dly,
                               logic [31:0] sdat);
    plan_t p;
    p.we = we; p.adr = adr; p.sel = sel; p.wdat = wdat;
    p.kind = kind; p.dly = dly; p.sdat = sdat;
    return p;
  endfunction

  // Called #1 after a rising edge.
  task automatic issue(plan_t p, bit hold);
    int unsigned guard;
    bus.core_data_req_i   = 1'b1;
    bus.core_data_addr_i  = p.adr;
    bus.core_data_we_i    = p.we;
    bus.core_data_be_i    = p.sel;
    bus.core_data_wdata_i = p.wdat;
    plan_q.push_back(p);
    exp_q.push_back(model(p));
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.core_data_gnt_o && guard < 40);
    check("grant", 32'(bus.core_data_gnt_o), 32'd1);
    @(posedge clk); #1;
    if (hold) begin
      guard = 0;
      while (guard < 40) begin
        @(negedge clk);
        guard++;
        check("gnt_low_while_busy", 32'(bus.core_data_gnt_o), 32'd0);
        if (bus.core_data_rvalid_o) break;
      end
      if (guard >= 40) fail("hold_wait_timeout");
      @(posedge clk); #1;
    end
    // Scramble the request fields: the bus must keep the latched values.
    bus.core_data_req_i   = 1'b0;
    bus.core_data_addr_i  = $urandom;
    bus.core_data_we_i    = 1'($urandom_range(0, 1));
    bus.core_data_be_i    = 4'($urandom_range(0, 15));
    bus.core_data_wdata_i = $urandom;
  endtask

  // Wishbone slave model and bus-side checks.
  initial begin
    int unsigned k;
    logic        prev_stb;
    logic        prev_gnt;
    plan_t       p;
    k = 0; prev_stb = 1'b0; prev_gnt = 1'b0;
    bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0; bus.wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      if (stray) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_err_i = 1'($urandom_range(0, 1));
        bus.wbm_dat_i = $urandom;
        k = 0;
      end else if (directed) begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        k = 0;
      end else if (bus.wbm_stb_o) begin
        k++;
        if (plan_q.size() == 0) begin
          fail("stb_without_request");
        end else begin
          p = plan_q[0];
          if (k == 1) check("stb_follows_grant", 32'(prev_gnt), 32'd1);
          check("cyc_with_stb", 32'(bus.wbm_cyc_o), 32'd1);
          check("wb_adr", bus.wbm_adr_o, p.adr);
          check("wb_sel", 32'(bus.wbm_sel_o), 32'(p.sel));
          check("wb_we", 32'(bus.wbm_we_o), 32'(p.we));
          check("wb_dat_o", bus.wbm_dat_o, p.wdat);
          if (p.kind != K_NONE && k == p.dly) begin
            bus.wbm_ack_i = (p.kind != K_ERR);
            bus.wbm_err_i = (p.kind != K_ACK);
            bus.wbm_dat_i = (p.kind == K_ACK) ? p.sdat : $urandom;
          end else begin
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            bus.wbm_dat_i = $urandom;
          end
        end
      end else begin
        if (prev_stb && plan_q.size() > 0) begin
          check("stb_cycles", k, stb_len(plan_q[0]));
          void'(plan_q.pop_front());
        end
        k = 0;
        check("idle_zero_bus", {bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_sel_o},
              32'd0);
        check("idle_zero_adr", bus.wbm_adr_o, 32'd0);
        check("idle_zero_dat", bus.wbm_dat_o, 32'd0);
        // Stray responses outside a cycle must be ignored.
        bus.wbm_ack_i = ($urandom_range(0, 3) == 0);
        bus.wbm_err_i = ($urandom_range(0, 7) == 0);
        bus.wbm_dat_i = $urandom;
      end
      prev_stb = (stray || directed) ? 1'b0 : bus.wbm_stb_o;
      prev_gnt = bus.core_data_gnt_o;
    end
  end

  // Response monitor / scoreboard.
  initial begin
    logic prev_rv;
    logic prev_stb_m;
    exp_t e;
    prev_rv = 1'b0; prev_stb_m = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.core_data_rvalid_o) begin
        if (exp_q.size() == 0) begin
          fail("spurious_rvalid");
        end else begin
          e = exp_q.pop_front();
          check("rdata", bus.core_data_rdata_o, e.rdata);
          check("err", 32'(bus.core_data_err_o), 32'(e.err));
          check("rvalid_after_last_stb", 32'(prev_stb_m), 32'd1);
          check("rvalid_single_cycle", 32'(prev_rv), 32'd0);
        end
      end
      prev_rv    = bus.core_data_rvalid_o;
      prev_stb_m = bus.wbm_stb_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int unsigned guard;
    bus.core_data_req_i   = 1'b0;
    bus.core_data_addr_i  = '0;
    bus.core_data_we_i    = 1'b0;
    bus.core_data_be_i    = '0;
    bus.core_data_wdata_i = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
    check("reset_rvalid", 32'(bus.core_data_rvalid_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_reset_outputs",
          {bus.core_data_gnt_o, bus.core_data_rvalid_o, bus.core_data_err_o,
           bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
    check("post_reset_rdata", bus.core_data_rdata_o, 32'd0);
    @(posedge clk); #1;

    // Directed cases.
    issue(mk(1'b0, 32'h3000_0010, 4'hF, 32'h0, K_ACK, 2, 32'hCAFE_F00D), 1'b0);
    issue(mk(1'b1, 32'h3000_0020, 4'b0011, 32'h1234_5678, K_ACK, 1, 32'hDEAD_BEEF), 1'b0);
    issue(mk(1'b0, 32'h3000_0030, 4'hF, 32'h0, K_NONE, 1, 32'h1111_2222), 1'b0);
    issue(mk(1'b0, 32'h3000_0040, 4'hF, 32'h0, K_BOTH, 2, 32'h3333_4444), 1'b0);
    issue(mk(1'b0, 32'h3000_0050, 4'hF, 32'h0, K_ACK, TIMEOUT, 32'h5555_6666), 1'b0);
    issue(mk(1'b1, 32'h3000_0060, 4'b1100, 32'hA5A5_5A5A, K_ERR, 3, 32'h0), 1'b1);
    issue(mk(1'b0, 32'h3000_0070, 4'hF, 32'h0, K_ACK, 1, 32'h0BAD_F00D), 1'b1);
    issue(mk(1'b0, 32'h3000_0080, 4'hF, 32'h0, K_ACK, 1, 32'h7777_8888), 1'b0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      issue(rand_plan(), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) fail("drain_timeout");
    #1;

    // Reset in the middle of a bus cycle.
    directed = 1'b1;
    bus.core_data_req_i  = 1'b1;
    bus.core_data_addr_i = 32'h3000_0090;
    bus.core_data_we_i   = 1'b0;
    @(negedge clk);
    check("rst_test_grant", 32'(bus.core_data_gnt_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_test_in_bus", {bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_bus_drop", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.core_data_rvalid_o},
          32'd0);
    check("gnt_in_reset", 32'(bus.core_data_gnt_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.core_data_req_i = 1'b0;
    stray = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_stray_ack_ignored",
            {bus.wbm_cyc_o, bus.wbm_stb_o, bus.core_data_rvalid_o}, 32'd0);
    end
    @(posedge clk); #1;
    stray    = 1'b0;
    directed = 1'b0;
    @(posedge clk); #1;

    // Recovery after reset.
    issue(mk(1'b0, 32'h3000_00A0, 4'hF, 32'h0, K_ACK, 2, 32'h600D_CAFE), 1'b0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) fail("final_drain_timeout");
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
